// File: rtl/input_conditioner_pkg.sv
// Shared definitions for the input conditioner family (sync and async tops).
package input_conditioner_pkg;

  localparam int DEFAULT_SYNC_STAGES     = 2;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 16;
  localparam int DEFAULT_GLITCH_W        = 8;

  // Debounce FSM encoding; bit 1 set means the accepted level is high.
  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    QUAL_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    QUAL_LOW    = 2'd3
  } state_t;

  // Accepted level implied by a state: high while stable high or qualifying a fall.
  function automatic logic state_is_high(input state_t st);
    return (st == STABLE_HIGH) || (st == QUAL_LOW);
  endfunction

  // True while a candidate transition is being qualified.
  function automatic logic state_is_qual(input state_t st);
    return (st == QUAL_HIGH) || (st == QUAL_LOW);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// N-flop synchronizer for a single asynchronous bit; q is the last stage.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the raw bit through the chain to let metastability resolve.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      // NOTE: non-blocking so every stage samples its predecessor's old value;
      // blocking here would collapse the chain into a single flop.
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/input_conditioner.sv
// Synchronizes and debounces a raw asynchronous bit into a clean level with
// rise/fall event pulses and a saturating count of aborted transitions.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int GLITCH_W        = DEFAULT_GLITCH_W
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_raw,
  input  logic                i_clear,
  output logic                o_level,
  output logic                o_rise,
  output logic                o_fall,
  output logic                o_busy,
  output logic [GLITCH_W-1:0] o_glitch_cnt
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             abort;
  logic             level_next;

  sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (i_clk),
    .rst_n(i_reset),
    .d    (i_raw),
    .q    (s)
  );

  // A candidate is abandoned as soon as the synchronized input returns to the old level.
  assign abort      = ((state == QUAL_HIGH) && !s) || ((state == QUAL_LOW) && s);
  assign level_next = state_is_high(state);

  // Debounce FSM: a new level is accepted only after DEBOUNCE_CYCLES stable samples.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state <= STABLE_LOW;
      cnt   <= '0;
    end else begin
      unique case (state)
        STABLE_LOW: begin
          if (s) begin
            state <= QUAL_HIGH;
            cnt   <= CNT_W'(1);
          end
        end
        QUAL_HIGH: begin
          if (!s) begin
            state <= STABLE_LOW;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= STABLE_HIGH;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STABLE_HIGH: begin
          if (!s) begin
            state <= QUAL_LOW;
            cnt   <= CNT_W'(1);
          end
        end
        QUAL_LOW: begin
          if (s) begin
            state <= STABLE_HIGH;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= STABLE_LOW;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= STABLE_LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Saturating glitch counter; a clear in the same cycle as an abort wins.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_glitch_cnt <= '0;
    end else if (i_clear) begin
      o_glitch_cnt <= '0;
    end else if (abort && (o_glitch_cnt != '1)) begin
      o_glitch_cnt <= o_glitch_cnt + GLITCH_W'(1);
    end
  end

  // Registered outputs decoded from the state; edges compare against the previous level.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_level <= 1'b0;
      o_rise  <= 1'b0;
      o_fall  <= 1'b0;
      o_busy  <= 1'b0;
    end else begin
      o_level <= level_next;
      o_rise  <= level_next && !o_level;
      o_fall  <= !level_next && o_level;
      o_busy  <= state_is_qual(state);
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner: default instance plus a
// SYNC_STAGES=3 / DEBOUNCE_CYCLES=2 instance sharing clock and reset.
module tb_input_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       raw_a, clear_a, raw_b, clear_b;
  logic       level_a, rise_a, fall_a, busy_a;
  logic       level_b, rise_b, fall_b, busy_b;
  logic [7:0] glitch_a, glitch_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  input_conditioner dut_a (
    .i_clk       (clk),
    .i_reset     (rst_n),
    .i_raw       (raw_a),
    .i_clear     (clear_a),
    .o_level     (level_a),
    .o_rise      (rise_a),
    .o_fall      (fall_a),
    .o_busy      (busy_a),
    .o_glitch_cnt(glitch_a)
  );

  input_conditioner #(
    .SYNC_STAGES    (3),
    .DEBOUNCE_CYCLES(2),
    .GLITCH_W       (8)
  ) dut_b (
    .i_clk       (clk),
    .i_reset     (rst_n),
    .i_raw       (raw_b),
    .i_clear     (clear_b),
    .o_level     (level_b),
    .o_rise      (rise_b),
    .o_fall      (fall_b),
    .o_busy      (busy_b),
    .o_glitch_cnt(glitch_b)
  );

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    int rises;
    rises   = 0;
    rst_n   = 1'b0;
    raw_a   = 1'b1;
    raw_b   = 1'b0;
    clear_a = 1'b0;
    clear_b = 1'b0;
    #2;
    tick(3);
    n_checks++;
    if ({level_a, rise_a, fall_a, busy_a} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 0000", {level_a, rise_a, fall_a, busy_a});
    end
    n_checks++;
    if (glitch_a !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_glitch: got %0d expected 0", glitch_a);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      tick(1);
      if (rise_a) rises++;
      if (k == 18) begin
        n_checks++;
        if (level_a !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_rise_early: level at edge 18 got %b expected 0", level_a);
        end
      end
      if (k == 19) begin
        n_checks++;
        if ({level_a, rise_a} !== 2'b11) begin
          n_fail++;
          $display("FAIL reset_rise_edge19: level,rise got %b expected 11", {level_a, rise_a});
        end
      end
      if (k == 20) begin
        n_checks++;
        if ({level_a, rise_a} !== 2'b10) begin
          n_fail++;
          $display("FAIL reset_rise_edge20: level,rise got %b expected 10", {level_a, rise_a});
        end
      end
    end
    n_checks++;
    if (rises != 1) begin
      n_fail++;
      $display("FAIL reset_rise_count: got %0d expected 1", rises);
    end
  endtask

  task automatic test_clean_fall;
    int busy_bad;
    busy_bad = 0;
    raw_a = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      tick(1);
      if (busy_a !== ((k >= 4) && (k <= 18))) busy_bad++;
      if (k == 18) begin
        n_checks++;
        if ({level_a, fall_a} !== 2'b10) begin
          n_fail++;
          $display("FAIL fall_edge18: level,fall got %b expected 10", {level_a, fall_a});
        end
      end
      if (k == 19) begin
        n_checks++;
        if ({level_a, fall_a, rise_a} !== 3'b010) begin
          n_fail++;
          $display("FAIL fall_edge19: level,fall,rise got %b expected 010", {level_a, fall_a, rise_a});
        end
      end
      if (k == 20) begin
        n_checks++;
        if (fall_a !== 1'b0) begin
          n_fail++;
          $display("FAIL fall_pulse_width: fall at edge 20 got %b expected 0", fall_a);
        end
      end
    end
    n_checks++;
    if (busy_bad != 0) begin
      n_fail++;
      $display("FAIL fall_busy_window: %0d cycles wrong, expected 0", busy_bad);
    end
    n_checks++;
    if (glitch_a !== 8'd0) begin
      n_fail++;
      $display("FAIL fall_glitch: got %0d expected 0", glitch_a);
    end
  endtask

  task automatic test_bounce;
    int rises;
    rises = 0;
    raw_a = 1'b1;
    tick(5);
    raw_a = 1'b0;
    tick(3);
    raw_a = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      tick(1);
      if (rise_a) rises++;
      if (k == 18 || k == 19) begin
        n_checks++;
        if (level_a !== (k == 19)) begin
          n_fail++;
          $display("FAIL bounce_level_edge%0d: got %b expected %b", k, level_a, (k == 19));
        end
      end
    end
    n_checks++;
    if (rises != 1) begin
      n_fail++;
      $display("FAIL bounce_rise_count: got %0d expected 1", rises);
    end
    n_checks++;
    if (glitch_a !== 8'd1) begin
      n_fail++;
      $display("FAIL bounce_glitch: got %0d expected 1", glitch_a);
    end
  endtask

  // Input returns high exactly when the fall count would have completed.
  task automatic test_late_bounce;
    int drops;
    drops = 0;
    raw_a = 1'b0;
    tick(15);
    raw_a = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      tick(1);
      if (!level_a || fall_a) drops++;
    end
    n_checks++;
    if (drops != 0) begin
      n_fail++;
      $display("FAIL late_bounce_level: %0d cycles low or falling, expected 0", drops);
    end
    n_checks++;
    if (glitch_a !== 8'd2) begin
      n_fail++;
      $display("FAIL late_bounce_glitch: got %0d expected 2", glitch_a);
    end
  endtask

  task automatic test_saturation;
    raw_a = 1'b0;
    tick(25);
    n_checks++;
    if ({level_a, glitch_a} !== {1'b0, 8'd2}) begin
      n_fail++;
      $display("FAIL sat_setup: level %b glitch %0d expected 0 and 2", level_a, glitch_a);
    end
    for (int i = 0; i < 300; i++) begin
      raw_a = 1'b1;
      tick(3);
      raw_a = 1'b0;
      tick(5);
      if (i == 251 || i == 252 || i == 299) begin
        n_checks++;
        if (glitch_a !== ((i == 251) ? 8'd254 : 8'd255)) begin
          n_fail++;
          $display("FAIL sat_count_%0d: got %0d expected %0d", i + 1, glitch_a,
                   (i == 251) ? 254 : 255);
        end
      end
    end
    n_checks++;
    if (level_a !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_level: got %b expected 0", level_a);
    end
  endtask

  // Clear lands on the same edge the glitch aborts.
  task automatic test_clear_with_glitch;
    raw_a = 1'b1;
    tick(3);
    raw_a = 1'b0;
    tick(2);
    clear_a = 1'b1;
    tick(1);
    clear_a = 1'b0;
    n_checks++;
    if (glitch_a !== 8'd0) begin
      n_fail++;
      $display("FAIL clear_win: got %0d expected 0", glitch_a);
    end
    tick(4);
    n_checks++;
    if (glitch_a !== 8'd0) begin
      n_fail++;
      $display("FAIL clear_after: got %0d expected 0", glitch_a);
    end
  endtask

  task automatic test_idle;
    int activity;
    activity = 0;
    raw_a = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick(1);
      if (busy_a || rise_a || fall_a || level_a) activity++;
    end
    n_checks++;
    if (activity != 0) begin
      n_fail++;
      $display("FAIL idle_quiet: %0d active cycles, expected 0", activity);
    end
  endtask

  task automatic test_reset_mid_qual;
    int rises;
    rises = 0;
    raw_a = 1'b1;
    tick(10);
    n_checks++;
    if (busy_a !== 1'b1) begin
      n_fail++;
      $display("FAIL midq_busy_before: got %b expected 1", busy_a);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy_a, level_a, glitch_a} !== {1'b0, 1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL midq_reset: busy %b level %b glitch %0d expected 0 0 0", busy_a, level_a, glitch_a);
    end
    tick(2);
    rst_n = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      tick(1);
      if (rise_a) rises++;
      if (k == 18 || k == 19) begin
        n_checks++;
        if (level_a !== (k == 19)) begin
          n_fail++;
          $display("FAIL midq_level_edge%0d: got %b expected %b", k, level_a, (k == 19));
        end
      end
    end
    n_checks++;
    if ({rises == 1, glitch_a} !== {1'b1, 8'd0}) begin
      n_fail++;
      $display("FAIL midq_after: rises %0d glitch %0d expected 1 and 0", rises, glitch_a);
    end
  endtask

  task automatic test_small_config;
    int rises;
    rises = 0;
    raw_b = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      if (k == 5 || k == 6) begin
        n_checks++;
        if ({level_b, rise_b} !== ((k == 6) ? 2'b11 : 2'b00)) begin
          n_fail++;
          $display("FAIL small_rise_edge%0d: level,rise got %b expected %b", k,
                   {level_b, rise_b}, (k == 6) ? 2'b11 : 2'b00);
        end
      end
    end
    raw_b = 1'b0;
    tick(10);
    n_checks++;
    if ({level_b, glitch_b} !== {1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL small_fall: level %b glitch %0d expected 0 and 0", level_b, glitch_b);
    end
    raw_b = 1'b1;
    tick(1);
    raw_b = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      if (level_b || rise_b) rises++;
    end
    n_checks++;
    if (rises != 0) begin
      n_fail++;
      $display("FAIL small_pulse_level: %0d cycles high, expected 0", rises);
    end
    n_checks++;
    if (glitch_b !== 8'd1) begin
      n_fail++;
      $display("FAIL small_pulse_glitch: got %0d expected 1", glitch_b);
    end
  endtask

  initial begin
    test_reset();
    test_clean_fall();
    test_bounce();
    test_late_bounce();
    test_saturation();
    test_clear_with_glitch();
    test_idle();
    test_reset_mid_qual();
    test_small_config();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
